// File: rtl/simple_spi_slave.sv
// Wishbone-mapped SPI slave with 4-deep TX/RX FIFOs, all four cpol/cpha modes,
// and the SPI pins oversampled through clk_i synchronizers.
module simple_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [1:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    input  logic       sck_i,
    input  logic       csn_i,
    input  logic       mosi_i,
    output logic       miso_o
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sck_pipe, csn_pipe, mosi_pipe;
    logic       sck_s, csn_s, mosi_s, sck_d, csn_d;
    logic       spie, spe, cpol, cpha;
    logic       spif, wcol, rovr, tun;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh, rx_sh;

    logic [7:0] tx_mem [0:3];
    logic [7:0] rx_mem [0:3];
    logic [1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [2:0] tx_count, rx_count;
    logic       tx_full, tx_empty, rx_full, rx_empty;

    logic sck_rise, sck_fall, csn_rise, csn_fall, sample_edge, shift_edge;
    logic start, stop, active, byte_done, tx_load, tx_pop, tun_set;
    logic rx_push, rovr_set;
    logic [7:0] tx_load_val, rx_byte;
    logic wr_cyc, rd_cyc, cpu_rx_pop, cpu_tx_push, wcol_set, spe_clear;
    logic [3:0] w1c;

    // Synchronizers: sck idles 0 and csn idles 1 out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sck_pipe  <= '0;
            csn_pipe  <= '1;
            mosi_pipe <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck_i};
            csn_pipe  <= {csn_pipe[SYNC_STAGES-2:0], csn_i};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi_i};
            sck_d     <= sck_s;
            csn_d     <= csn_s;
        end
    end

    assign sck_s  = sck_pipe[SYNC_STAGES-1];
    assign csn_s  = csn_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign csn_rise    = csn_s & ~csn_d;
    assign csn_fall    = ~csn_s & csn_d;
    assign sample_edge = (cpol == cpha) ? sck_rise : sck_fall;
    assign shift_edge  = (cpol == cpha) ? sck_fall : sck_rise;

    assign tx_full  = (tx_count == 3'd4);
    assign tx_empty = (tx_count == 3'd0);
    assign rx_full  = (rx_count == 3'd4);
    assign rx_empty = (rx_count == 3'd0);

    assign start     = (state == IDLE) && spe && csn_fall;
    assign stop      = (state == SHIFT) && (!spe || csn_rise);
    assign active    = (state == SHIFT) && !stop;
    assign byte_done = active && sample_edge && (bit_cnt == 3'd7);
    // cpha=0 preloads at csn fall and at each byte end; cpha=1 loads on the
    // first shift edge of a byte. Shift edges at bit_cnt==0 never shift.
    assign tx_load     = cpha ? (active && shift_edge && (bit_cnt == 3'd0))
                              : (start || byte_done);
    assign tx_pop      = tx_load && !tx_empty;
    assign tun_set     = tx_load && tx_empty;
    assign tx_load_val = tx_empty ? 8'hFF : tx_mem[tx_rd];
    assign rx_byte     = {rx_sh[6:0], mosi_s};

    // Wishbone: ack_o rises the cycle after cyc_i&stb_i and drops the next;
    // writes and read side effects (RX pop) happen only while ack_o is high.
    assign wr_cyc      = ack_o & cyc_i & stb_i & we_i;
    assign rd_cyc      = ack_o & cyc_i & stb_i & ~we_i;
    assign cpu_rx_pop  = rd_cyc && (adr_i == 2'd2) && !rx_empty;
    assign cpu_tx_push = wr_cyc && (adr_i == 2'd2) && (!tx_full || tx_pop);
    assign wcol_set    = wr_cyc && (adr_i == 2'd2) && tx_full && !tx_pop;
    assign spe_clear   = wr_cyc && (adr_i == 2'd0) && spe && !dat_i[6];
    assign rx_push     = byte_done && (!rx_full || cpu_rx_pop);
    assign rovr_set    = byte_done && rx_full && !cpu_rx_pop;
    assign w1c         = (wr_cyc && (adr_i == 2'd1)) ? dat_i[7:4] : 4'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        bit_cnt <= 3'd0;
                        tx_sh   <= tx_load ? tx_load_val : 8'h00;
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (tx_load)
                            tx_sh <= tx_load_val;
                        else if (shift_edge && (bit_cnt != 3'd0))
                            tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso_o = (state == SHIFT) && tx_sh[7];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o    <= 1'b0;
            inta_o   <= 1'b0;
            spie     <= 1'b0;
            spe      <= 1'b0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            spif     <= 1'b0;
            wcol     <= 1'b0;
            rovr     <= 1'b0;
            tun      <= 1'b0;
            tx_rd    <= 2'd0;
            tx_wr    <= 2'd0;
            tx_count <= 3'd0;
            rx_rd    <= 2'd0;
            rx_wr    <= 2'd0;
            rx_count <= 3'd0;
        end else begin
            ack_o  <= cyc_i & stb_i & ~ack_o;
            inta_o <= spie & spif;
            if (wr_cyc && (adr_i == 2'd0)) begin
                spie <= dat_i[7];
                spe  <= dat_i[6];
                cpol <= dat_i[3];
                cpha <= dat_i[2];
            end
            // Hardware sets win over a same-cycle write-1-to-clear.
            spif <= (spif & ~w1c[3]) | byte_done;
            wcol <= (wcol & ~w1c[2]) | wcol_set;
            rovr <= (rovr & ~w1c[1]) | rovr_set;
            tun  <= (tun  & ~w1c[0]) | tun_set;
            if (spe_clear) begin
                tx_rd    <= 2'd0;
                tx_wr    <= 2'd0;
                tx_count <= 3'd0;
                rx_rd    <= 2'd0;
                rx_wr    <= 2'd0;
                rx_count <= 3'd0;
            end else begin
                if (cpu_tx_push) tx_wr <= tx_wr + 2'd1;
                if (tx_pop)      tx_rd <= tx_rd + 2'd1;
                tx_count <= tx_count + {2'b00, cpu_tx_push} - {2'b00, tx_pop};
                if (rx_push)     rx_wr <= rx_wr + 2'd1;
                if (cpu_rx_pop)  rx_rd <= rx_rd + 2'd1;
                rx_count <= rx_count + {2'b00, rx_push} - {2'b00, cpu_rx_pop};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cpu_tx_push) tx_mem[tx_wr] <= dat_i;
        if (rx_push)     rx_mem[rx_wr] <= rx_byte;
    end

    always_comb begin
        dat_o = 8'h00;
        if (rd_cyc) begin
            case (adr_i)
                2'd0: dat_o = {spie, spe, 2'b00, cpol, cpha, 2'b00};
                2'd1: dat_o = {spif, wcol, rovr, tun, tx_full, tx_empty, rx_full, rx_empty};
                2'd2: dat_o = rx_empty ? 8'h00 : rx_mem[rx_rd];
                default: dat_o = {1'b0, tx_count, 1'b0, rx_count};
            endcase
        end
    end
endmodule

// File: tb/tb_simple_spi_slave.sv
// Directed bench for simple_spi_slave: a bus master, a bit-banged SPI master
// and hand-computed expected register and byte values.
module tb_simple_spi_slave;
    localparam int H = 80;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [1:0] adr_i = 2'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o, inta_o, miso_o;
    logic       sck_i  = 1'b0;
    logic       csn_i  = 1'b1;
    logic       mosi_i = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rx, spcr_v;
    logic       cpol_v, cpha_v;

    simple_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o),
        .sck_i(sck_i), .csn_i(csn_i), .mosi_i(mosi_i), .miso_o(miso_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                       output logic [7:0] rd);
        int n;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!ack_o && n < 8);
        check("ack", {7'b0, ack_o}, 8'h01);
        rd = dat_o;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] d);
        logic [7:0] dummy;
        bus(1'b1, adr, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [7:0] exp);
        logic [7:0] v;
        bus(1'b0, adr, 8'h00, v);
        check(tag, v, exp);
    endtask

    task automatic spi_begin(input logic cpol);
        @(negedge clk_i); #2;
        sck_i = cpol; mosi_i = 1'b0;
        #H; csn_i = 1'b0;
        #H;
    endtask

    task automatic spi_bits(input logic cpol, input logic cpha, input logic [7:0] tx,
                            input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_i = tx[7-i]; #H;
                sck_i = ~cpol; r = {r[6:0], miso_o}; #H;
                sck_i = cpol;
            end else begin
                sck_i = ~cpol; mosi_i = tx[7-i]; #H;
                sck_i = cpol; r = {r[6:0], miso_o}; #H;
            end
        end
    endtask

    task automatic spi_end();
        #H; csn_i = 1'b1;
        #(2*H);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack",  {7'b0, ack_o},  8'h00);
        check("rst_inta", {7'b0, inta_o}, 8'h00);
        check("rst_miso", {7'b0, miso_o}, 8'h00);
        check("rst_dat",  dat_o,          8'h00);
        @(negedge clk_i); rst_i = 1'b1;
        rd_chk("rst_spcr", 2'd0, 8'h00);
        rd_chk("rst_spsr", 2'd1, 8'h05);
        rd_chk("rst_sper", 2'd3, 8'h00);

        // One byte each way in all four modes
        for (int m = 0; m < 4; m++) begin
            cpol_v = m[1];
            cpha_v = m[0];
            spcr_v = 8'h40 | 8'(m << 2);
            wr(2'd0, spcr_v);
            wr(2'd2, 8'hA5);
            spi_begin(cpol_v);
            spi_bits(cpol_v, cpha_v, 8'h3C, 8, rx);
            spi_end();
            check($sformatf("mode%0d_miso", m), rx, 8'hA5);
            check($sformatf("mode%0d_inta_off", m), {7'b0, inta_o}, 8'h00);
            rd_chk($sformatf("mode%0d_spsr", m), 2'd1, cpha_v ? 8'h84 : 8'h94);
            rd_chk($sformatf("mode%0d_spdr", m), 2'd2, 8'h3C);
            rd_chk($sformatf("mode%0d_spcr", m), 2'd0, spcr_v);
            wr(2'd1, 8'hF0);
            rd_chk($sformatf("mode%0d_spsr_clr", m), 2'd1, 8'h05);
        end

        // TX underrun
        wr(2'd0, 8'h40);
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'h55, 8, rx);
        spi_end();
        check("tun_miso", rx, 8'hFF);
        rd_chk("tun_spsr", 2'd1, 8'h94);
        wr(2'd1, 8'h10);
        rd_chk("tun_clr", 2'd1, 8'h84);
        rd_chk("tun_spdr", 2'd2, 8'h55);
        wr(2'd1, 8'hF0);

        // RX overrun: five bytes, no reads
        spi_begin(1'b0);
        for (int b = 1; b <= 5; b++) begin
            spi_bits(1'b0, 1'b0, 8'(b), 8, rx);
            check($sformatf("rovr_miso%0d", b), rx, 8'hFF);
        end
        spi_end();
        rd_chk("rovr_spsr", 2'd1, 8'hB6);
        rd_chk("rovr_sper", 2'd3, 8'h04);
        for (int b = 1; b <= 4; b++)
            rd_chk($sformatf("rovr_spdr%0d", b), 2'd2, 8'(b));
        rd_chk("rovr_spdr_empty", 2'd2, 8'h00);
        rd_chk("rovr_spsr_after", 2'd1, 8'hB5);
        wr(2'd1, 8'hF0);

        // TX write collision, then flush by clearing spe
        for (int b = 0; b < 5; b++)
            wr(2'd2, 8'h11 + 8'(b));
        rd_chk("wcol_spsr", 2'd1, 8'h49);
        rd_chk("wcol_sper", 2'd3, 8'h40);
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'h00, 8, rx);
        spi_end();
        check("wcol_miso", rx, 8'h11);
        rd_chk("wcol_sper2", 2'd3, 8'h21);
        wr(2'd0, 8'h00);
        rd_chk("flush_spcr", 2'd0, 8'h00);
        rd_chk("flush_sper", 2'd3, 8'h00);
        rd_chk("flush_spsr", 2'd1, 8'hC5);
        wr(2'd0, 8'h40);
        wr(2'd1, 8'hF0);
        rd_chk("flush_spsr_clr", 2'd1, 8'h05);

        // Aborted partial byte followed by a full byte
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'hFF, 3, rx);
        spi_end();
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'h81, 8, rx);
        spi_end();
        rd_chk("abort_sper", 2'd3, 8'h01);
        rd_chk("abort_spdr", 2'd2, 8'h81);
        wr(2'd1, 8'hF0);

        // Interrupt
        wr(2'd0, 8'hC0);
        check("inta_idle", {7'b0, inta_o}, 8'h00);
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'h5A, 8, rx);
        spi_end();
        check("inta_set", {7'b0, inta_o}, 8'h01);
        wr(2'd1, 8'h80);
        repeat (2) @(posedge clk_i);
        #1;
        check("inta_clr", {7'b0, inta_o}, 8'h00);
        rd_chk("inta_spdr", 2'd2, 8'h5A);

        // Reset asserted mid-byte
        wr(2'd0, 8'h40);
        wr(2'd1, 8'hF0);
        wr(2'd2, 8'hFF);
        spi_begin(1'b0);
        spi_bits(1'b0, 1'b0, 8'h00, 4, rx);
        #H;
        check("midrst_miso_before", {7'b0, miso_o}, 8'h01);
        rst_i = 1'b0;
        #1;
        check("midrst_miso", {7'b0, miso_o}, 8'h00);
        csn_i = 1'b1; sck_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        rd_chk("midrst_spcr", 2'd0, 8'h00);
        rd_chk("midrst_spsr", 2'd1, 8'h05);
        rd_chk("midrst_sper", 2'd3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/simple_spi_slave.md
SIMPLE_SPI_SLAVE -- requirements
Module: simple_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of clk_i synchronizer flops on sck_i, csn_i and mosi_i (minimum 2).
REQ-002 clk_i  in  1  system clock; all logic on the rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe and write enable.
REQ-005 adr_i  in  2  register select: 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER.
REQ-006 dat_i  in  8  write data; dat_o  out  8  read data.
REQ-007 ack_o  out  1  transfer acknowledge; inta_o  out  1  interrupt request.
REQ-008 sck_i, csn_i, mosi_i  in  1 each  SPI clock, active-low select and master-out data, asynchronous to clk_i.
REQ-009 miso_o  out  1  slave-out data.

Function
REQ-010 ack_o SHALL assert one cycle after cyc_i&stb_i and SHALL be registered as cyc_i&stb_i&~ack_o, so every access takes exactly 2 cycles; writes and read side effects occur in the ack cycle only.
REQ-011 SPCR (R/W): [7] spie, [6] spe, [3] cpol, [2] cpha; bits [5:4] and [1:0] read 0.
REQ-012 SPSR: [7] spif, [6] wcol, [5] rovr, [4] tun are write-1-to-clear; [3] txfull, [2] txempty, [1] rxfull, [0] rxempty are read-only.
REQ-013 SPDR write SHALL push the 4-entry TX FIFO; if full, data is dropped and wcol set, except when the SPI side pops in the same cycle, in which case the write is accepted.
REQ-014 SPDR read SHALL return and pop the RX FIFO head; when empty it returns 0x00 and does not pop.
REQ-015 SPER SHALL be read-only {1'b0, tx_count[2:0], 1'b0, rx_count[2:0]}; writes are ignored.
REQ-016 inta_o SHALL be registered spie & spif.
REQ-017 sck_i, csn_i and mosi_i SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized values; clk_i SHALL be at least 8x the sck frequency.
REQ-018 Sample edge SHALL be rising sck when cpol==cpha and falling otherwise; the shift edge is the opposite edge; data is MSB first.
REQ-019 FSM states: IDLE (csn high or spe=0) and SHIFT; IDLE->SHIFT on synchronized csn fall with spe=1; SHIFT->IDLE on csn rise or spe clear.
REQ-020 A TX load SHALL pop the TX FIFO head into the shift register; if the FIFO is empty, 0xFF is loaded and tun set.
REQ-021 cpha=0: a TX load SHALL occur at csn fall and on the sample edge completing each byte, with MSB on miso_o before the first sample edge.
REQ-022 cpha=1: a TX load SHALL occur on the first shift edge of each byte, which also presents the MSB.
REQ-023 A 3-bit counter SHALL count sample edges; on the 8th edge the received byte is pushed to the RX FIFO, spif is set and the counter wraps to 0.
REQ-024 If the RX FIFO is full when a byte completes, the byte is dropped and rovr set, unless a CPU SPDR read pops in the same cycle, in which case the push succeeds.
REQ-025 A csn rise mid-byte SHALL discard the partial byte, leave the FIFOs unchanged and clear the bit counter.
REQ-026 miso_o SHALL be 0 in IDLE, otherwise the shift register MSB.
REQ-027 Clearing spe SHALL flush both FIFOs, return the FSM to IDLE and leave SPCR and the sticky flags unchanged.
REQ-028 A CPU w1c in the same cycle as a hardware set of the same flag SHALL leave the flag set.

Reset
REQ-029 While rst_i=0: SPCR=0x00, SPSR=0x05, both FIFOs empty, FSM=IDLE, bit counter=0, ack_o=0, inta_o=0, miso_o=0, dat_o=0x00, synchronizers cleared to sck=cpol-independent 0 and csn=1.
REQ-030 Reset assertion mid-byte SHALL abort the transfer immediately; after release the block is in the full reset state.

Verification
REQ-031 For each cpol/cpha (4 modes): SPCR=0x40|mode<<2, push 0xA5, master sends 0x3C -> master receives 0xA5; SPDR read gives 0x3C; spif=1.
REQ-032 TX empty, master clocks one byte -> master receives 0xFF, tun=1; writing 0x10 to SPSR clears tun.
REQ-033 Master sends 5 bytes 0x01..0x05 without reads -> RX holds 0x01..0x04, rovr=1, SPER[2:0]=4, rxfull=1.
REQ-034 5 SPDR writes with no SPI activity -> fifth dropped, wcol=1, txfull=1, SPER[6:4]=4.
REQ-035 csn raised after 3 bits, then full byte 0x81 -> only 0x81 in RX, rx_count=1.
REQ-036 spie=1, byte received -> inta_o=1 one cycle after spif; write 0x80 to SPSR -> inta_o=0.
